// File: rtl/reg_file_ser_master.sv
// Serial initiator for the 3-wire register-file interface: one strobe cycle,
// then address and data MSB first on DIN; read data is captured from DOUT.
module reg_file_ser_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WR,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  BUSY,
    output logic                  WR_EN,
    output logic                  RD_EN,
    output logic                  DIN,
    input  logic                  DOUT
);
    localparam int FW   = ADDR_WIDTH + DATA_WIDTH;
    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, STRB, ADDR, DATA, DONE} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [FW-1:0]         sh, sh_nxt;
    logic [DATA_WIDTH-1:0] rd_sh, rd_sh_nxt;
    logic [DATA_WIDTH-1:0] rdata_nxt;
    logic                  wr_q, wr_nxt;
    logic                  din_nxt;
    logic                  accept;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sh_nxt    = sh;
        wr_nxt    = wr_q;
        rd_sh_nxt = rd_sh;
        rdata_nxt = RSP_RDATA;
        din_nxt   = 1'b0;
        accept    = (state == IDLE) && REQ_VALID && REQ_READY;

        unique case (state)
            IDLE: if (accept) begin
                state_nxt = STRB;
                cnt_nxt   = '0;
                wr_nxt    = REQ_WR;
                // Reads load a zero data field so DIN idles low through DATA.
                sh_nxt    = {REQ_ADDR, (REQ_WR ? REQ_WDATA : {DATA_WIDTH{1'b0}})};
            end
            STRB: begin
                state_nxt = ADDR;
                cnt_nxt   = ADDR_LAST;
            end
            ADDR: begin
                if (cnt == '0) begin
                    state_nxt = DATA;
                    cnt_nxt   = DATA_LAST;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DATA: begin
                if (!wr_q) begin
                    rd_sh_nxt = (rd_sh << 1) | DATA_WIDTH'(DOUT);
                    if (cnt == '0) rdata_nxt = rd_sh_nxt;
                end
                if (cnt == '0) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // DIN is registered, so the bit for the coming cycle leaves the shifter now.
        if (state_nxt == ADDR || state_nxt == DATA) begin
            din_nxt = sh[FW-1];
            sh_nxt  = sh << 1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt       <= '0;
            sh        <= '0;
            rd_sh     <= '0;
            wr_q      <= 1'b0;
            REQ_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            BUSY      <= 1'b0;
            WR_EN     <= 1'b0;
            RD_EN     <= 1'b0;
            DIN       <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            sh        <= sh_nxt;
            rd_sh     <= rd_sh_nxt;
            wr_q      <= wr_nxt;
            REQ_READY <= (state_nxt == IDLE);
            RSP_VALID <= (state_nxt == DONE);
            RSP_RDATA <= rdata_nxt;
            BUSY      <= (state_nxt != IDLE);
            WR_EN     <= (state_nxt == STRB) && wr_nxt;
            RD_EN     <= (state_nxt == STRB) && !wr_nxt;
            DIN       <= din_nxt;
        end
    end

endmodule

// File: doc/reg_file_ser_master.md
Name: reg_file_ser_master

Overview:
Serial initiator for the team's 3-wire serial register-file interface (WR_EN/RD_EN strobes, DIN, DOUT).
- Accepts parallel register-access requests over a valid/ready handshake.
- Serialises each request as a frame: strobe, then address MSB first, then data MSB first.
- For reads, captures the responder's DOUT bits and returns the result as a parallel word.
- Sits between a CPU/config bus adapter and one or more serial register-file responders.

Parameters:
ADDR_WIDTH, 8, address bits shifted per frame.
DATA_WIDTH, 8, data bits shifted or captured per frame.

Ports:
CLK  input  1  clock; all logic on rising edge.
RSTN  input  1  asynchronous active-low reset.
REQ_VALID  input  1  request present.
REQ_READY  output  1  master can accept a request.
REQ_WR  input  1  1 = write, 0 = read.
REQ_ADDR  input  ADDR_WIDTH  target register address.
REQ_WDATA  input  DATA_WIDTH  write data (ignored for reads).
RSP_VALID  output  1  one-cycle pulse: transaction complete.
RSP_RDATA  output  DATA_WIDTH  read data; valid with RSP_VALID on reads.
BUSY  output  1  frame in progress (not IDLE).
WR_EN  output  1  write-frame start strobe to responder.
RD_EN  output  1  read-frame start strobe to responder.
DIN  output  1  serial address/data to responder.
DOUT  input  1  serial read data from responder.

Behaviour:
- Reset (asynchronous, RSTN low):
  - State goes to IDLE. Bit counter, shift register and latched request clear to 0.
  - Outputs: REQ_READY=1 one cycle after release (0 while RSTN low), RSP_VALID=0, RSP_RDATA=0, BUSY=0, WR_EN=0, RD_EN=0, DIN=0.
  - Reset mid-frame aborts the frame immediately; the request is lost and no RSP_VALID is issued.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE -> STRB -> ADDR -> DATA -> DONE -> IDLE.
- IDLE:
  - REQ_READY=1.
  - On an edge with REQ_VALID=1, latch REQ_WR, REQ_ADDR and REQ_WDATA, then go to STRB.
  - REQ_READY=0 in every other state. REQ_VALID held while the master is busy is not consumed.
- STRB (1 cycle): WR_EN=REQ_WR and RD_EN=!REQ_WR for exactly this cycle; DIN=0.
- ADDR (ADDR_WIDTH cycles): DIN=addr[ADDR_WIDTH-1-k] in cycle k. Cycle 0 of ADDR immediately follows the strobe cycle.
- DATA (DATA_WIDTH cycles):
  - Write: DIN=wdata[DATA_WIDTH-1-k] in cycle k.
  - Read: DIN=0. DOUT is sampled at the rising edge ending each DATA cycle and shifted in MSB first.
- DONE (1 cycle):
  - RSP_VALID=1 and DIN=0.
  - On reads, RSP_RDATA is loaded from the shift register so it is valid in this cycle, and it holds until the next read completes.
  - Writes leave RSP_RDATA unchanged.
  - The mandatory idle cycle guarantees the responder's internal counter has drained before the next strobe.
- Timing:
  - Acceptance edge to strobe: 1 cycle.
  - Frame length: 1 + ADDR_WIDTH + DATA_WIDTH + 1 = 18 cycles at defaults.
  - Back-to-back throughput: one transaction per 19 cycles (REQ_READY is high again the cycle after DONE).
- BUSY=1 in STRB, ADDR, DATA and DONE.
- The bit counter counts down within ADDR and DATA and reloads on each state change; there is no wrap-around beyond the frame.
- WR_EN and RD_EN are never high together and never high outside STRB.
- DOUT is ignored on writes and outside DATA on reads.

Test Plan:
1. Write addr 0x78, data 0xA5 → WR_EN high for one cycle, the cycle after acceptance. DIN then reads 0,1,1,1,1,0,0,0 followed by 1,0,1,0,0,1,0,1. RSP_VALID pulses 18 cycles after acceptance; RSP_RDATA stays unchanged; RD_EN stays 0 throughout.
2. Read addr 0x55 with a DOUT model returning 0x33 MSB first in the DATA cycles → RD_EN pulses once and DIN shows 0,1,0,1,0,1,0,1 then 0s. RSP_VALID pulses with RSP_RDATA=0x33, and RSP_RDATA holds 0x33 afterwards.
3. Hold REQ_VALID high with two queued requests (write 0x06=0x5A, then read 0x06 returning 0x5A) → the second is accepted exactly 19 cycles after the first. REQ_READY is 0 throughout the first frame. Responses arrive in order with RDATA=0x5A.
4. Assert RSTN low during ADDR cycle 3 of a write → WR_EN, RD_EN, DIN, BUSY and RSP_VALID go 0 immediately with no RSP_VALID pulse. After release, REQ_READY=1 and a new write 0x34=0xFF completes correctly.
5. Pulse REQ_VALID while BUSY, then drop it before IDLE → no acceptance and no extra frame on WR_EN/RD_EN.
6. Integration with the serial register-file responder: write 0xA1=0xC3, then read 0xA1 → RSP_RDATA=0xC3. A write to the read-only register followed by a read returns that register's reset value, unchanged.
